// File: rtl/pipe_perf_monitor.sv
// Cycle / retire / hazard-event performance monitor for the 5-stage pipe.
// Ports: clk, rst_n (async, active-low); start/stop/clear window control;
//        retire and evt[NUM_EVT] count strobes; snap captures cycles/retired;
//        cycles, retired, evt_count (channel k at [k*SIZE +: SIZE]),
//        cycles_snap, retired_snap, running, done, overflow (sticky).
module pipe_perf_monitor #(
    parameter int SIZE       = 32,
    parameter int NUM_EVT    = 4,
    parameter int MAX_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    retire,
    input  logic [NUM_EVT-1:0]      evt,
    input  logic                    snap,
    output logic [SIZE-1:0]         cycles,
    output logic [SIZE-1:0]         retired,
    output logic [NUM_EVT*SIZE-1:0] evt_count,
    output logic [SIZE-1:0]         cycles_snap,
    output logic [SIZE-1:0]         retired_snap,
    output logic                    running,
    output logic                    done,
    output logic                    overflow
);

    localparam logic [SIZE-1:0] LP_ONES = '1;
    localparam logic [SIZE-1:0] LP_LAST = SIZE'(MAX_CYCLES - 1);
    localparam bit              LP_AUTO = (MAX_CYCLES != 0);

    if ((longint'(MAX_CYCLES) >> SIZE) != 0) begin : g_bad_max
        $error("MAX_CYCLES does not fit in a SIZE-bit counter");
    end

    // One-hot so running/done come straight off a state flop.
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SIZE-1:0]        r_cycles;
    logic [SIZE-1:0]        r_retired;
    logic [SIZE-1:0]        r_evt [NUM_EVT];
    logic [SIZE-1:0]        r_cycles_snap;
    logic [SIZE-1:0]        r_retired_snap;
    logic                   r_overflow;

    logic                   w_cnt;
    logic                   w_zero;
    logic                   w_last;
    logic                   w_sat_hit;
    logic [SIZE-1:0]        w_cyc_nxt;
    logic [SIZE-1:0]        w_ret_nxt;
    logic [SIZE-1:0]        w_evt_nxt [NUM_EVT];

    function automatic logic [SIZE-1:0] sat_inc(
        input logic [SIZE-1:0] v,
        input logic            en
    );
        return (en && (v != LP_ONES)) ? v + SIZE'(1) : v;
    endfunction

    assign w_cnt  = (r_state == S_RUN);
    assign w_zero = clear | start;
    // Final cycle of an auto-terminating window: cycles is about to hit MAX.
    assign w_last = LP_AUTO && w_cnt && (r_cycles == LP_LAST);

    // ---------------- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else if (start) begin
            w_state_nxt = S_RUN;
        end else if (r_state == S_RUN) begin
            if (w_last) begin
                w_state_nxt = S_DONE;
            end else if (stop) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // ---------------- FSM: outputs
    always_comb begin
        running = r_state[1];
        done    = r_state[2];
    end

    // ---------------- counter next values
    always_comb begin
        w_cyc_nxt = w_zero ? '0 : sat_inc(r_cycles, w_cnt);
        w_ret_nxt = w_zero ? '0 : sat_inc(r_retired, w_cnt & retire);
        w_sat_hit = w_cnt & ((r_cycles == LP_ONES) |
                             (retire & (r_retired == LP_ONES)));
        for (int k = 0; k < NUM_EVT; k++) begin
            w_evt_nxt[k] = w_zero ? '0 : sat_inc(r_evt[k], w_cnt & evt[k]);
            if (w_cnt && evt[k] && (r_evt[k] == LP_ONES)) begin
                w_sat_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles   <= '0;
            r_retired  <= '0;
            r_overflow <= 1'b0;
            for (int k = 0; k < NUM_EVT; k++) begin
                r_evt[k] <= '0;
            end
        end else begin
            r_cycles   <= w_cyc_nxt;
            r_retired  <= w_ret_nxt;
            r_overflow <= w_zero ? 1'b0 : (r_overflow | w_sat_hit);
            for (int k = 0; k < NUM_EVT; k++) begin
                r_evt[k] <= w_evt_nxt[k];
            end
        end
    end

    // Snapshot takes the post-edge value, so a same-cycle start gives 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles_snap  <= '0;
            r_retired_snap <= '0;
        end else if (clear) begin
            r_cycles_snap  <= '0;
            r_retired_snap <= '0;
        end else if (snap) begin
            r_cycles_snap  <= w_cyc_nxt;
            r_retired_snap <= w_ret_nxt;
        end
    end

    assign cycles       = r_cycles;
    assign retired      = r_retired;
    assign cycles_snap  = r_cycles_snap;
    assign retired_snap = r_retired_snap;
    assign overflow     = r_overflow;

    for (genvar g = 0; g < NUM_EVT; g++) begin : g_flat
        assign evt_count[g*SIZE +: SIZE] = r_evt[g];
    end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: three instances share stimulus
// (unlimited 32-bit, MAX_CYCLES=8, SIZE=4) and are checked per scenario.
module tb_pipe_perf_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, clear, retire, snap;
    logic [3:0] evt;

    logic [31:0]  a_cyc, a_ret, a_csnap, a_rsnap;
    logic [127:0] a_evt;
    logic         a_run, a_done, a_ovf;

    logic [31:0]  b_cyc, b_ret, b_csnap, b_rsnap;
    logic [127:0] b_evt;
    logic         b_run, b_done, b_ovf;

    logic [3:0]   c_cyc, c_ret, c_csnap, c_rsnap;
    logic [15:0]  c_evt;
    logic         c_run, c_done, c_ovf;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_perf_monitor #(.SIZE(32), .NUM_EVT(4), .MAX_CYCLES(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .clear(clear), .retire(retire), .evt(evt), .snap(snap),
        .cycles(a_cyc), .retired(a_ret), .evt_count(a_evt),
        .cycles_snap(a_csnap), .retired_snap(a_rsnap),
        .running(a_run), .done(a_done), .overflow(a_ovf)
    );

    pipe_perf_monitor #(.SIZE(32), .NUM_EVT(4), .MAX_CYCLES(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .clear(clear), .retire(retire), .evt(evt), .snap(snap),
        .cycles(b_cyc), .retired(b_ret), .evt_count(b_evt),
        .cycles_snap(b_csnap), .retired_snap(b_rsnap),
        .running(b_run), .done(b_done), .overflow(b_ovf)
    );

    pipe_perf_monitor #(.SIZE(4), .NUM_EVT(4), .MAX_CYCLES(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .clear(clear), .retire(retire), .evt(evt), .snap(snap),
        .cycles(c_cyc), .retired(c_ret), .evt_count(c_evt),
        .cycles_snap(c_csnap), .retired_snap(c_rsnap),
        .running(c_run), .done(c_done), .overflow(c_ovf)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and samples live 1ns after posedge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {start, stop, clear, retire, snap} = '0;
        evt = '0;
        #12;

        // ---- reset state
        chk("rst_cycles", a_cyc, 0);
        chk("rst_retired", a_ret, 0);
        chk("rst_running", a_run, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_snap", a_csnap, 0);
        rst_n = 1'b1;
        tick();

        // ---- 10 cycle window closed by stop
        pulse_start();
        chk("s1_run_after_start", a_run, 1);
        chk("s1_cyc_start", a_cyc, 0);
        retire = 1'b1;
        tick(9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        retire = 1'b0;
        chk("s1_cycles", a_cyc, 10);
        chk("s1_retired", a_ret, 10);
        chk("s1_running", a_run, 0);
        chk("s1_done", a_done, 0);
        tick(5);
        chk("s1_hold_cyc", a_cyc, 10);
        chk("s1_hold_ret", a_ret, 10);

        // ---- auto-terminating window, MAX_CYCLES=8
        pulse_start();
        for (int n = 1; n <= 8; n++) begin
            evt = 4'b0000;
            if (n == 3 || n == 4) evt[0] = 1'b1;
            if (n == 8) evt[2] = 1'b1;
            tick();
            if (n == 7) chk("s2_run_c7", b_run, 1);
        end
        evt = '0;
        chk("s2_done", b_done, 1);
        chk("s2_running", b_run, 0);
        chk("s2_cycles", b_cyc, 8);
        chk("s2_ev0", b_evt[31:0], 2);
        chk("s2_ev1", b_evt[63:32], 0);
        chk("s2_ev2", b_evt[95:64], 1);
        chk("s2_ev3", b_evt[127:96], 0);
        evt = 4'b1111;
        tick(3);
        evt = '0;
        chk("s2_hold_cyc", b_cyc, 8);
        chk("s2_hold_ev0", b_evt[31:0], 2);
        chk("s2_unlim_cyc", a_cyc, 11);

        // ---- SIZE=4 saturation
        pulse_start();
        tick(15);
        chk("s3_cyc15", c_cyc, 15);
        chk("s3_no_ovf_yet", c_ovf, 0);
        tick(5);
        chk("s3_sat_cyc", c_cyc, 15);
        chk("s3_ovf", c_ovf, 1);
        pulse_start();
        chk("s3_restart_cyc", c_cyc, 0);
        chk("s3_restart_ovf", c_ovf, 0);
        chk("s3_restart_run", c_run, 1);

        // ---- snapshot
        pulse_start();
        retire = 1'b1;
        tick(5);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        chk("s4_csnap", a_csnap, 6);
        chk("s4_rsnap", a_rsnap, 6);
        tick(3);
        chk("s4_live_cyc", a_cyc, 9);
        chk("s4_csnap_hold", a_csnap, 6);
        retire = 1'b0;

        // ---- priority: clear + start (+ snap) while running
        clear = 1'b1;
        start = 1'b1;
        snap = 1'b1;
        tick();
        {clear, start, snap} = '0;
        chk("p_clr_run", a_run, 0);
        chk("p_clr_cyc", a_cyc, 0);
        chk("p_clr_ret", a_ret, 0);
        chk("p_clr_csnap", a_csnap, 0);
        chk("p_clr_done", b_done, 0);

        // start + stop in IDLE -> RUN
        start = 1'b1;
        stop = 1'b1;
        tick();
        {start, stop} = '0;
        chk("p_ss_run", a_run, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("p_stop_idle", a_run, 0);
        chk("p_stop_cyc", a_cyc, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("p_stop2_run", a_run, 0);
        chk("p_stop2_cyc", a_cyc, 1);

        // ---- async reset mid-window
        pulse_start();
        retire = 1'b1;
        tick(5);
        chk("r_pre_cyc", a_cyc, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_cyc", a_cyc, 0);
        chk("r_async_ret", a_ret, 0);
        chk("r_async_run", a_run, 0);
        #3;
        rst_n = 1'b1;
        tick(2);
        chk("r_post_run", a_run, 0);
        chk("r_post_cyc", a_cyc, 0);
        retire = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
